sobel_fetch_seq: RTL and testbench

// - Upstream sequencer for ahb_master: walks a SRC image, fetches each 3x3 neighbourhood one byte
//   at a time through the master's read command, and hands the window to the Sobel core.
// - Takes the core's 8-bit edge result and issues a master write command to store it in the DST image.
// - One command in flight at a time; handshake on the master's busy flag.

---
 rtl/sobel_pkg.sv | 36 +++
 rtl/sobel_addr_gen.sv | 29 ++
 rtl/sobel_fetch_seq.sv | 186 ++++++++++++++++++
 tb/tb_sobel_fetch_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel fetch sequencer: master command encoding, FSM states, window size.
package sobel_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10
    } cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_ISSUE,
        RD_ACK,
        RD_DONE,
        EMIT,
        WAIT_RES,
        WR_ISSUE,
        WR_ACK,
        WR_DONE,
        ADVANCE
    } state_t;

    localparam int WIN_PIX = 9;

    // Window byte k sits at row k/3, column k%3.
    function automatic logic [7:0] k_row(input logic [3:0] k);
        if (k < 4'd3)      return 8'd0;
        else if (k < 4'd6) return 8'd1;
        else               return 8'd2;
    endfunction

    function automatic logic [7:0] k_col(input logic [3:0] k);
        return {4'b0000, k} - 8'd3 * k_row(k);
    endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// Combinational source/destination byte addresses for centre (x,y) and window byte k; wraps modulo 256.
module sobel_addr_gen
    import sobel_pkg::*;
#(
    parameter int         IMG_W    = 8,
    parameter logic [7:0] SRC_BASE = 8'h00,
    parameter logic [7:0] DST_BASE = 8'h80
) (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [3:0] k,
    output logic [7:0] addr_r,
    output logic [7:0] addr_w
);

    localparam logic [7:0] W_SRC = 8'(IMG_W);
    localparam logic [7:0] W_DST = 8'(IMG_W - 2);

    logic [7:0] row;
    logic [7:0] col;

    always_comb begin
        row    = y + k_row(k) - 8'd1;
        col    = x + k_col(k) - 8'd1;
        addr_r = SRC_BASE + row * W_SRC + col;
        addr_w = DST_BASE + (y - 8'd1) * W_DST + (x - 8'd1);
    end

endmodule

// File: rtl/sobel_fetch_seq.sv
// Walks the source image, fetches 3x3 windows via ahb_master, stores Sobel results to the destination.
// Build option FETCH_REUSE_EN: reuse two window columns on an x step, reading only the new column.
module sobel_fetch_seq
    import sobel_pkg::*;
#(
    parameter int         IMG_W    = 8,
    parameter int         IMG_H    = 8,
    parameter logic [7:0] SRC_BASE = 8'h00,
    parameter logic [7:0] DST_BASE = 8'h80
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   start,
    output logic                   done,
    input  logic                   mst_busy,
    input  logic [7:0]             data_r,
    output logic [1:0]             instruction,
    output logic [7:0]             addr_r,
    output logic [7:0]             addr_w,
    output logic [7:0]             data_w,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [WIN_PIX*8-1:0]   win_pix,
    input  logic                   res_valid,
    input  logic [7:0]             res_data
);

    localparam logic [7:0] X_LAST = 8'(IMG_W - 2);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 2);

    state_t                 state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [7:0]             x_q, x_d, y_q, y_d;
    logic [3:0]             k_q, k_d;
    logic                   col_only_q, col_only_d;
    logic [7:0]             addr_r_q, addr_r_d, addr_w_q, addr_w_d, data_w_q, data_w_d;
    logic                   win_valid_q, win_valid_d, done_q, done_d;
    logic [WIN_PIX*8-1:0]   win_q, win_d;
    logic [7:0]             gen_addr_r, gen_addr_w;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        cmd_d       = cmd_q;
        x_d         = x_q;
        y_d         = y_q;
        k_d         = k_q;
        col_only_d  = col_only_q;
        data_w_d    = data_w_q;
        win_valid_d = win_valid_q;
        win_d       = win_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: if (start) begin
                state_d    = RD_ISSUE;
                cmd_d      = CMD_READ;
                k_d        = 4'd0;
                col_only_d = 1'b0;
            end
            RD_ISSUE: state_d = RD_ACK;
            RD_ACK: if (mst_busy) begin
                cmd_d   = CMD_IDLE;
                state_d = RD_DONE;
            end
            RD_DONE: if (!mst_busy) begin
                win_d[{k_q, 3'b000} +: 8] = data_r;
                if (k_q == 4'd8) begin
                    state_d     = EMIT;
                    win_valid_d = 1'b1;
                end else begin
                    state_d = RD_ISSUE;
                    cmd_d   = CMD_READ;
                    k_d     = k_q + (col_only_q ? 4'd3 : 4'd1);
                end
            end
            EMIT: if (win_ready) begin
                win_valid_d = 1'b0;
                state_d     = WAIT_RES;
            end
            WAIT_RES: if (res_valid) begin
                data_w_d = res_data;
                state_d  = WR_ISSUE;
                cmd_d    = CMD_WRITE;
            end
            WR_ISSUE: state_d = WR_ACK;
            WR_ACK: if (mst_busy) begin
                cmd_d   = CMD_IDLE;
                state_d = WR_DONE;
            end
            WR_DONE: if (!mst_busy) state_d = ADVANCE;
            ADVANCE: begin
                if (x_q == X_LAST) begin
                    x_d        = 8'd1;
                    k_d        = 4'd0;
                    col_only_d = 1'b0;
                    if (y_q == Y_LAST) begin
                        y_d     = 8'd1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        y_d     = y_q + 8'd1;
                        state_d = RD_ISSUE;
                        cmd_d   = CMD_READ;
                    end
                end else begin
                    x_d     = x_q + 8'd1;
                    state_d = RD_ISSUE;
                    cmd_d   = CMD_READ;
`ifdef FETCH_REUSE_EN
                    // Slide the two overlapping columns left; only column dx=2 is fetched.
                    for (int r = 0; r < 3; r++) begin
                        win_d[24*r +: 8]     = win_q[24*r + 8 +: 8];
                        win_d[24*r + 8 +: 8] = win_q[24*r + 16 +: 8];
                    end
                    k_d        = 4'd2;
                    col_only_d = 1'b1;
`else
                    k_d        = 4'd0;
                    col_only_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sobel_addr_gen #(
        .IMG_W    (IMG_W),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE)
    ) u_addr_gen (
        .x      (x_d),
        .y      (y_d),
        .k      (k_d),
        .addr_r (gen_addr_r),
        .addr_w (gen_addr_w)
    );

    // Addresses are latched as a command is issued and held through its handshake.
    always_comb begin
        addr_r_d = (state_d == RD_ISSUE) ? gen_addr_r : addr_r_q;
        addr_w_d = (state_d == WR_ISSUE) ? gen_addr_w : addr_w_q;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_IDLE;
            x_q         <= 8'd1;
            y_q         <= 8'd1;
            k_q         <= 4'd0;
            col_only_q  <= 1'b0;
            addr_r_q    <= 8'd0;
            addr_w_q    <= 8'd0;
            data_w_q    <= 8'd0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            // NOTE: the window is a register bank on an output port, so it is cleared, not left X.
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_q         <= k_d;
            col_only_q  <= col_only_d;
            addr_r_q    <= addr_r_d;
            addr_w_q    <= addr_w_d;
            data_w_q    <= data_w_d;
            win_valid_q <= win_valid_d;
            done_q      <= done_d;
            win_q       <= win_d;
        end
    end

    assign instruction = cmd_q;
    assign addr_r      = addr_r_q;
    assign addr_w      = addr_w_q;
    assign data_w      = data_w_q;
    assign win_valid   = win_valid_q;
    assign win_pix     = win_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sobel_fetch_seq.sv
// Bench for sobel_fetch_seq: 4x4 and 5x3 ramp images, 1-cycle-busy master model, centre+1 core model.
module tb_sobel_fetch_seq;

    logic HCLK = 1'b0;
    logic HRESET = 1'b0;
    always #5 HCLK = ~HCLK;

    int tests = 0;
    int fails = 0;

    // Instance 0: 4x4, instance 1: 5x3.
    logic        start0 = 0, done0, busy0, wv0, wr0 = 1, rv0, rvc0, spur0 = 0;
    logic [7:0]  rdata0, ar0, aw0, dw0, rd0, rdc0, pend0;
    logic [1:0]  instr0;
    logic [71:0] wp0;
    int          cnt0;
    logic        start1 = 0, done1, busy1, wv1, wr1 = 1, rvc1;
    logic [7:0]  rdata1, ar1, aw1, dw1, rdc1, pend1;
    logic [1:0]  instr1;
    logic [71:0] wp1;
    int          cnt1;

    logic [71:0] exp_win0[$], exp_win1[$];
    logic [15:0] exp_wr0[$];
    int          hs0 = 0, done_cnt0 = 0, done_cnt1 = 0, rdcnt1 = 0;
    logic [71:0] first_win0 = '0;
    logic        first_seen0 = 0;
    logic [31:0] wlog0 = '0;

    assign rv0 = rvc0 | spur0;
    assign rd0 = spur0 ? 8'hEE : rdc0;

    sobel_fetch_seq #(.IMG_W(4), .IMG_H(4), .SRC_BASE(8'h00), .DST_BASE(8'h80)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start0), .done(done0), .mst_busy(busy0),
        .data_r(rdata0), .instruction(instr0), .addr_r(ar0), .addr_w(aw0), .data_w(dw0),
        .win_valid(wv0), .win_ready(wr0), .win_pix(wp0), .res_valid(rv0), .res_data(rd0));

    sobel_fetch_seq #(.IMG_W(5), .IMG_H(3), .SRC_BASE(8'h00), .DST_BASE(8'h80)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start1), .done(done1), .mst_busy(busy1),
        .data_r(rdata1), .instruction(instr1), .addr_r(ar1), .addr_w(aw1), .data_w(dw1),
        .win_valid(wv1), .win_ready(wr1), .win_pix(wp1), .res_valid(rvc1), .res_data(rdc1));

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Master responders: accept a command when idle, busy for exactly one cycle; src[i] = i.
    always @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            busy0 <= 0; rdata0 <= 0;
        end else if (busy0) busy0 <= 0;
        else if (instr0 != 2'b00) begin
            busy0 <= 1;
            if (instr0 == 2'b01) rdata0 <= ar0;
        end
    end
    always @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            busy1 <= 0; rdata1 <= 0;
        end else if (busy1) busy1 <= 0;
        else if (instr1 != 2'b00) begin
            busy1 <= 1;
            if (instr1 == 2'b01) rdata1 <= ar1;
        end
    end

    // Sobel core stand-ins: result = centre + 1, three cycles after the window handshake.
    always @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            rvc0 <= 0; rdc0 <= 0; pend0 <= 0; cnt0 <= 0;
        end else begin
            rvc0 <= 0;
            if (cnt0 != 0) begin
                cnt0 <= cnt0 - 1;
                if (cnt0 == 1) begin rvc0 <= 1; rdc0 <= pend0; end
            end
            if (wv0 && wr0) begin cnt0 <= 3; pend0 <= wp0[39:32] + 8'd1; end
        end
    end
    always @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            rvc1 <= 0; rdc1 <= 0; pend1 <= 0; cnt1 <= 0;
        end else begin
            rvc1 <= 0;
            if (cnt1 != 0) begin
                cnt1 <= cnt1 - 1;
                if (cnt1 == 1) begin rvc1 <= 1; rdc1 <= pend1; end
            end
            if (wv1 && wr1) begin cnt1 <= 3; pend1 <= wp1[39:32] + 8'd1; end
        end
    end

    // Scoreboard monitors, sampled mid-cycle.
    always @(negedge HCLK) begin
        logic [71:0] ew;
        logic [15:0] ewr;
        if (HRESET) begin
            if (wv0 && wr0) begin
                ew = 'x;
                if (exp_win0.size() != 0) ew = exp_win0.pop_front();
                check("win0", wp0, ew);
                if (!first_seen0) begin first_win0 = wp0; first_seen0 = 1; end
                hs0++;
            end
            if (instr0 == 2'b10 && !busy0) begin
                ewr = 'x;
                if (exp_wr0.size() != 0) ewr = exp_wr0.pop_front();
                check("write0", {56'd0, aw0, dw0}, {56'd0, ewr});
                wlog0 = {wlog0[23:0], dw0};
            end
            if (done0) done_cnt0++;
            if (wv1 && wr1) begin
                ew = 'x;
                if (exp_win1.size() != 0) ew = exp_win1.pop_front();
                check("win1", wp1, ew);
            end
            if (instr1 == 2'b01 && !busy1) rdcnt1++;
            if (done1) done_cnt1++;
        end
    end

    function automatic logic [71:0] model_win(input int w, input int x, input int y);
        logic [71:0] v;
        int a;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            a = ((y + k / 3 - 1) * w + (x + k % 3 - 1)) % 256;
            v[8*k +: 8] = a[7:0];
        end
        return v;
    endfunction

    task automatic push_frame0();
        logic [71:0] v;
        for (int y = 1; y <= 2; y++)
            for (int x = 1; x <= 2; x++) begin
                v = model_win(4, x, y);
                exp_win0.push_back(v);
                exp_wr0.push_back({8'(8'h80 + (y - 1) * 2 + (x - 1)), 8'(v[39:32] + 8'd1)});
            end
    endtask

    task automatic pulse_start(input int which);
        @(posedge HCLK); #1;
        if (which == 0) start0 = 1; else start1 = 1;
        @(posedge HCLK); #1;
        start0 = 0; start1 = 0;
    endtask

    task automatic wait_done(input int which, input int base, input string tag);
        int n = 0;
        while (((which == 0) ? done_cnt0 : done_cnt1) == base && n < 3000) begin
            @(negedge HCLK); n++;
        end
        check(tag, (which == 0) ? done_cnt0 : done_cnt1, base + 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_instr"}, instr0, 0);
        check({tag, "_addr_r"}, ar0, 0);
        check({tag, "_addr_w"}, aw0, 0);
        check({tag, "_data_w"}, dw0, 0);
        check({tag, "_win_valid"}, wv0, 0);
        check({tag, "_win_pix"}, wp0, 0);
        check({tag, "_done"}, done0, 0);
    endtask

    initial begin
        logic [71:0] snap;
        int base, n;

        // Reset state
        repeat (3) @(negedge HCLK);
        check_outputs_zero("reset");
        @(posedge HCLK); #1; HRESET = 1;

        // Frame A: 4x4 ramp, core always ready
        base = done_cnt0;
        push_frame0();
        pulse_start(0);
        wait_done(0, base, "frameA_done");
        check("frameA_first_win", first_win0, 72'h0A0908060504020100);
        check("frameA_write_bytes", wlog0, 32'h06070A0B);
        check("frameA_win_left", exp_win0.size(), 0);
        check("frameA_wr_left", exp_wr0.size(), 0);

        // 5x3 frame on the second instance: windows and read-command count
        base = done_cnt1;
        n = rdcnt1;
        for (int x = 1; x <= 3; x++) exp_win1.push_back(model_win(5, x, 1));
        pulse_start(1);
        wait_done(1, base, "frame5x3_done");
`ifdef FETCH_REUSE_EN
        check("frame5x3_reads", rdcnt1 - n, 15);
`else
        check("frame5x3_reads", rdcnt1 - n, 27);
`endif
        check("frame5x3_win_left", exp_win1.size(), 0);

        // Frame B: stalled window, spurious res_valid in EMIT, start pulsed mid-frame
        base = done_cnt0;
        push_frame0();
        @(posedge HCLK); #1; wr0 = 0;
        pulse_start(0);
        n = 0;
        while (!wv0 && n < 500) begin @(negedge HCLK); n++; end
        check("stall_win_valid_seen", wv0, 1);
        snap = wp0;
        @(posedge HCLK); #1; spur0 = 1; start0 = 1;
        @(posedge HCLK); #1; spur0 = 0; start0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            check("stall_win_valid", wv0, 1);
            check("stall_win_pix", wp0, snap);
            check("stall_no_cmd", instr0, 0);
        end
        @(posedge HCLK); #1; wr0 = 1;
        wait_done(0, base, "frameB_done");
        check("frameB_win_left", exp_win0.size(), 0);
        check("frameB_wr_left", exp_wr0.size(), 0);

        // Frame C: reset during RD_DONE of window 2, then a clean restart
        push_frame0();
        base = hs0;
        pulse_start(0);
        n = 0;
        while (hs0 == base && n < 1000) begin @(negedge HCLK); n++; end
        check("abort_first_window", hs0, base + 1);
        n = 0;
        while (!(instr0 == 2'b01 && busy0) && n < 1000) begin @(negedge HCLK); n++; end
        check("abort_rd_ack_seen", {instr0, busy0}, 3'b011);
        @(posedge HCLK); #1; HRESET = 0; #1;
        check_outputs_zero("abort");
        exp_win0.delete();
        exp_wr0.delete();
        base = done_cnt0;
        repeat (2) @(posedge HCLK);
        #1; HRESET = 1;
        repeat (20) @(negedge HCLK);
        check("abort_no_done", done_cnt0, base);
        check("abort_idle", instr0, 0);
        push_frame0();
        pulse_start(0);
        n = 0;
        while (instr0 != 2'b01 && n < 100) begin @(negedge HCLK); n++; end
        check("restart_cmd", instr0, 2'b01);
        check("restart_addr", ar0, 8'h00);
        wait_done(0, base, "frameD_done");
        check("frameD_win_left", exp_win0.size(), 0);
        check("frameD_wr_left", exp_wr0.size(), 0);

        repeat (5) @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
